regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//   Two-port arbiter/sequencer in front of the 4x4 register file (register_file_4x4).
//   Requesters A and B each issue single read or write ops via a req/gnt/done handshake.
//   Round-robin arbitration; drives the file's write strobe, write/read addresses and data in.
//   Captures read data, so both clients share one single-write-port file without conflicts.
// PARAMETERS
//   DW  4  data width; must match the register file data width
//   AW  2  address width; must match the register file depth (2**AW entries)
// PORTS
//   clk            in   1   system clock, rising edge
//   clr            in   1   asynchronous active-high reset
//   a_req, b_req   in   1   op request; held until sampled in IDLE
//   a_we, b_we     in   1   1 = write, 0 = read
//   a_addr, b_addr in   AW  target register
//   a_wdata,b_wdata in  DW  write data
//   a_gnt, b_gnt   out  1   high in ISSUE and ACK of that requester's op
//   a_done,b_done  out  1   one-cycle pulse in ACK
//   a_rdata,b_rdata out DW  read result; loaded only on that requester's reads
//   rf_write       out  1   register file write strobe
//   rf_wr_address  out  AW  register file write address
//   rf_r_address   out  AW  register file read address
//   rf_in          out  DW  register file write data
//   rf_out         in   DW  register file read data (combinational from rf_r_address)
// BEHAVIOUR
//   FSM states: IDLE -> ISSUE -> ACK -> IDLE. One op per 3 cycles.
//   IDLE: if a_req or b_req, pick the winner and capture its we/addr/wdata; go to ISSUE.
//   Round-robin: a last_owner flag. On a tie, the requester that is not last_owner wins.
//   At reset, last_owner = B, so A wins the first tie.
//   A single requester always wins. last_owner updates on entry to ISSUE.
//   ISSUE: gnt=1. Write: rf_write=1, rf_wr_address=addr, rf_in=wdata; the file stores at the end-of-cycle edge.
//   Read in ISSUE: rf_r_address=addr, rf_write=0. rdata <= rf_out at the end-of-cycle edge.
//   ACK: gnt=1, done=1, rf_write=0. rdata is valid here and holds until that requester's next read.
//   Operands are captured at grant. Dropping req or changing operands after IDLE has no effect: the op completes.
//   A req deasserted before it is sampled in IDLE is dropped silently. No queueing.
//   Max wait for a requester with the other one busy: one full op (3 cycles) plus its own 3-cycle op.
//   rf_write is asserted in ISSUE only, never in IDLE or ACK, and never for reads.
//   Read-after-write to the same address by the other requester returns the new value (the write completed in the earlier ISSUE).
//   rf_wr_address and rf_in hold their last value when idle. rf_r_address = captured addr.
//   Reset (clr=1, any state, asynchronous):
//     - State goes to IDLE; any in-flight op is aborted with no done.
//     - rf_write=0 immediately.
//     - All outputs are 0: gnt, done, rdata, rf_* addresses, rf_in.
//     - last_owner = B.
// CONFIGURATION
//   RF_ARB_LOCK_EN defined:
//     - Adds inputs a_lock and b_lock (1 bit each).
//     - In ACK, if the owner's lock=1 and its req=1, the FSM goes straight to ISSUE for the same owner.
//     - Operands are recaptured in ACK, giving a 2-cycle cadence; the other requester is blocked while the lock holds.
//     - Dropping lock returns to IDLE after the current ACK, and normal round-robin resumes.
//   RF_ARB_LOCK_EN undefined:
//     - The lock ports do not exist.
//     - ACK always returns to IDLE, giving strict alternation under contention.
// TESTING
//   1 Reset mid-write: assert clr during ISSUE of an A write -> rf_write, a_gnt and a_done drop to 0 the same cycle; no done pulse.
//     After release, an A read of addr 0 -> a_rdata=4'h0.
//   2 A writes 4'hA to addr 1 -> a_gnt high 2 cycles; rf_write=1 for 1 cycle with rf_wr_address=1, rf_in=4'hA; a_done pulses in cycle 2.
//     Then a B read of addr 1 -> b_rdata=4'hA when b_done=1.
//   3 a_req and b_req both held high from reset release -> grants A,B,A,B. Each done is spaced 3 cycles; never both gnt.
//   4 b_req stuck high and A requests once -> A granted at the first IDLE after the current B op, i.e. within 3 cycles.
//   5 a_req pulsed 1 cycle while B is mid-op -> no A op, no a_done. a_req dropped during ISSUE -> op completes, a_done pulses.
//   6 RF_ARB_LOCK_EN, a_lock=1, A writes 4'h1,4'h2,4'h3 to addr 0..2 with b_req high -> a_done every 2 cycles, b_gnt low.
//     Drop a_lock -> B is granted next.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin req/gnt/done sequencer that shares one single-write-port 4x4 register file between clients A and B.
// Optional back-to-back lock mode (a_lock/b_lock ports) is enabled by defining RF_ARB_LOCK_EN.
module regfile_arbiter #(
    parameter int DW = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          a_req,
    input  logic          b_req,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic [DW-1:0] b_wdata,
`ifdef RF_ARB_LOCK_EN
    input  logic          a_lock,
    input  logic          b_lock,
`endif
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_done,
    output logic          b_done,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          rf_write,
    output logic [AW-1:0] rf_wr_address,
    output logic [AW-1:0] rf_r_address,
    output logic [DW-1:0] rf_in,
    input  logic [DW-1:0] rf_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    logic [1:0]    state;
    logic          owner;
    logic          last_owner;
    logic          op_we;
    logic [AW-1:0] op_addr;

    logic          winner;
    logic          relock;
    logic          cap_sel;
    logic          capture;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;

    // On a tie the requester that did not own the previous op wins.
    always_comb begin
        if (a_req && b_req) begin
            winner = ~last_owner;
        end else if (a_req) begin
            winner = OWNER_A;
        end else begin
            winner = OWNER_B;
        end
    end

`ifdef RF_ARB_LOCK_EN
    assign relock = (owner == OWNER_A) ? (a_lock && a_req) : (b_lock && b_req);
`else
    assign relock = 1'b0;
`endif

    // Operands come from the new winner in IDLE, or from the locked owner in ACK.
    assign cap_sel   = (state == IDLE) ? winner : owner;
    assign capture   = ((state == IDLE) && (a_req || b_req)) || ((state == ACK) && relock);
    assign cap_we    = (cap_sel == OWNER_A) ? a_we    : b_we;
    assign cap_addr  = (cap_sel == OWNER_A) ? a_addr  : b_addr;
    assign cap_wdata = (cap_sel == OWNER_A) ? a_wdata : b_wdata;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= IDLE;
            owner         <= OWNER_A;
            last_owner    <= OWNER_B;
            op_we         <= 1'b0;
            op_addr       <= '0;
            rf_wr_address <= '0;
            rf_in         <= '0;
        end else begin
            case (state)
                IDLE:    if (a_req || b_req) state <= ISSUE;
                ISSUE:   state <= ACK;
                ACK:     state <= relock ? ISSUE : IDLE;
                default: state <= IDLE;
            endcase
            if (capture) begin
                owner      <= cap_sel;
                last_owner <= cap_sel;
                op_we      <= cap_we;
                op_addr    <= cap_addr;
                if (cap_we) begin
                    rf_wr_address <= cap_addr;
                    rf_in         <= cap_wdata;
                end
            end
        end
    end

    // Read data is sampled from the file at the end of ISSUE and held until that client's next read.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if ((state == ISSUE) && !op_we) begin
            if (owner == OWNER_A) begin
                a_rdata <= rf_out;
            end else begin
                b_rdata <= rf_out;
            end
        end
    end

    assign a_gnt        = ((state == ISSUE) || (state == ACK)) && (owner == OWNER_A);
    assign b_gnt        = ((state == ISSUE) || (state == ACK)) && (owner == OWNER_B);
    assign a_done       = (state == ACK) && (owner == OWNER_A);
    assign b_done       = (state == ACK) && (owner == OWNER_B);
    assign rf_write     = (state == ISSUE) && op_we;
    assign rf_r_address = op_addr;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus randomized traffic checked every cycle against a transaction-level model.
module tb_regfile_arbiter;

    logic       clk;
    logic       clr;
    logic       a_req, b_req, a_we, b_we;
    logic [1:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;
`ifdef RF_ARB_LOCK_EN
    logic       a_lock, b_lock;
`endif
    logic       a_gnt, b_gnt, a_done, b_done;
    logic [3:0] a_rdata, b_rdata;
    logic       rf_write;
    logic [1:0] rf_wr_address, rf_r_address;
    logic [3:0] rf_in, rf_out;

    regfile_arbiter #(.DW(4), .AW(2)) dut (
        .clk(clk), .clr(clr),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
`ifdef RF_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_done(a_done), .b_done(b_done),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .rf_write(rf_write), .rf_wr_address(rf_wr_address), .rf_r_address(rf_r_address),
        .rf_in(rf_in), .rf_out(rf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for register_file_4x4: registered write, combinational read.
    logic [3:0] rf_mem [4];
    assign rf_out = rf_mem[rf_r_address];
    always @(posedge clk) if (rf_write) rf_mem[rf_wr_address] <= rf_in;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Model: m_stage 0 = nothing in flight, 1 = file-access cycle, 2 = completion cycle.
    int         m_stage;
    bit         m_owner, m_last, m_we;
    logic [1:0] m_addr;
    logic [3:0] m_wdata;
    logic [3:0] m_rdata [2];
    logic [3:0] m_mem [4];

    task automatic modelReset();
        m_stage = 0; m_owner = 0; m_last = 1; m_we = 0; m_addr = 0; m_wdata = 0;
        m_rdata[0] = 0; m_rdata[1] = 0;
    endtask

    task automatic modelTake(input bit who);
        m_owner = who;
        m_last  = who;
        m_we    = who ? b_we    : a_we;
        m_addr  = who ? b_addr  : a_addr;
        m_wdata = who ? b_wdata : a_wdata;
        m_stage = 1;
    endtask

    task automatic modelAdvance();
        bit keep;
        if (m_stage == 0) begin
            if (a_req && b_req) modelTake(!m_last);
            else if (a_req)     modelTake(1'b0);
            else if (b_req)     modelTake(1'b1);
        end else if (m_stage == 1) begin
            if (m_we) m_mem[m_addr] = m_wdata;
            else      m_rdata[m_owner] = m_mem[m_addr];
            m_stage = 2;
        end else begin
            keep = 1'b0;
`ifdef RF_ARB_LOCK_EN
            keep = m_owner ? (b_lock && b_req) : (a_lock && a_req);
`endif
            if (keep) modelTake(m_owner);
            else      m_stage = 0;
        end
    endtask

    always @(negedge clk) begin
        if (clr) modelReset();
        checkOutput("a_gnt",  a_gnt,  (m_stage != 0) && !m_owner);
        checkOutput("b_gnt",  b_gnt,  (m_stage != 0) &&  m_owner);
        checkOutput("a_done", a_done, (m_stage == 2) && !m_owner);
        checkOutput("b_done", b_done, (m_stage == 2) &&  m_owner);
        checkOutput("rf_write", rf_write, (m_stage == 1) && m_we);
        checkOutput("a_rdata", a_rdata, m_rdata[0]);
        checkOutput("b_rdata", b_rdata, m_rdata[1]);
        checkOutput("rf_r_address", rf_r_address, m_addr);
        if (clr) begin
            checkOutput("rf_wr_address_rst", rf_wr_address, 0);
            checkOutput("rf_in_rst", rf_in, 0);
        end else begin
            if ((m_stage == 1) && m_we) begin
                checkOutput("rf_wr_address", rf_wr_address, m_addr);
                checkOutput("rf_in", rf_in, m_wdata);
            end
            modelAdvance();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ar, input logic aw, input logic [1:0] aa, input logic [3:0] ad,
                                 input logic br, input logic bw, input logic [1:0] ba, input logic [3:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic resetPulse();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    int done_owner [$];
    int done_cycle [$];
    int n;
    bit seen;

    initial begin
        for (int i = 0; i < 4; i++) begin
            rf_mem[i] = 4'h0;
            m_mem[i]  = 4'h0;
        end
        modelReset();
        clr = 1'b1;
`ifdef RF_ARB_LOCK_EN
        a_lock = 1'b0; b_lock = 1'b0;
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        clr = 1'b0;

        // Reset during an A write must abort it with no store and no done.
        applyStimulus(1, 1, 2'd0, 4'h5, 0, 0, 0, 0);
        tick();
        checkOutput("t1_issue_gnt", a_gnt, 1);
        checkOutput("t1_issue_write", rf_write, 1);
        clr = 1'b1;
        #1;
        checkOutput("t1_rst_rf_write", rf_write, 0);
        checkOutput("t1_rst_a_gnt", a_gnt, 0);
        checkOutput("t1_rst_a_done", a_done, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        clr = 1'b0;
        applyStimulus(1, 0, 2'd0, 4'h0, 0, 0, 0, 0);
        tick();
        a_req = 1'b0;
        tick();
        checkOutput("t1_read_done", a_done, 1);
        checkOutput("t1_read_addr0", a_rdata, 4'h0);
        tick();

        // A writes 4'hA to addr 1, then B reads it back.
        applyStimulus(1, 1, 2'd1, 4'hA, 0, 0, 0, 0);
        tick();
        checkOutput("t2_issue_gnt", a_gnt, 1);
        checkOutput("t2_issue_write", rf_write, 1);
        checkOutput("t2_wr_address", rf_wr_address, 1);
        checkOutput("t2_rf_in", rf_in, 4'hA);
        checkOutput("t2_issue_done", a_done, 0);
        a_req = 1'b0;
        tick();
        checkOutput("t2_ack_gnt", a_gnt, 1);
        checkOutput("t2_ack_done", a_done, 1);
        checkOutput("t2_ack_write", rf_write, 0);
        tick();
        checkOutput("t2_idle_gnt", a_gnt, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 2'd1, 0);
        tick();
        b_req = 1'b0;
        tick();
        checkOutput("t2_b_done", b_done, 1);
        checkOutput("t2_b_rdata", b_rdata, 4'hA);
        tick();

        // Both requesting from reset release: strict alternation starting with A.
        applyStimulus(1, 0, 2'd1, 0, 1, 0, 2'd2, 0);
        resetPulse();
        done_owner.delete();
        done_cycle.delete();
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (a_gnt && b_gnt) checkOutput("t3_both_gnt", 1, 0);
            if (a_done) begin done_owner.push_back(0); done_cycle.push_back(c); end
            if (b_done) begin done_owner.push_back(1); done_cycle.push_back(c); end
        end
        checkOutput("t3_done_count", done_owner.size(), 4);
        if (done_owner.size() == 4) begin
            for (int k = 0; k < 4; k++) checkOutput("t3_owner_order", done_owner[k], k % 2);
            for (int k = 1; k < 4; k++) checkOutput("t3_done_spacing", done_cycle[k] - done_cycle[k-1], 3);
        end

        // B stuck high: a single A request is granted within 3 cycles.
        a_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            seen = b_gnt && !b_done;
        end
        checkOutput("t4_b_issue_seen", seen, 1);
        applyStimulus(1, 0, 2'd2, 0, 1, 0, 2'd3, 0);
        n = 0;
        seen = 0;
        for (int c = 1; c <= 10 && !seen; c++) begin
            tick();
            n = c;
            seen = a_gnt;
        end
        checkOutput("t4_a_granted", seen, 1);
        checkOutput("t4_wait_le3", n <= 3, 1);
        a_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            seen = a_done;
        end
        checkOutput("t4_a_done", seen, 1);

        // A pulse that is never sampled in IDLE is dropped.
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            tick();
            seen = b_gnt && !b_done;
        end
        checkOutput("t5_b_issue_seen", seen, 1);
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (a_gnt || a_done) seen = 1;
        end
        checkOutput("t5_pulse_dropped", seen, 0);
        b_req = 1'b0;
        tick(); tick(); tick();
        a_req = 1'b1;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            seen = a_gnt;
        end
        checkOutput("t5_a_granted", seen, 1);
        a_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            tick();
            seen = a_done;
        end
        checkOutput("t5_dropped_req_completes", seen, 1);
        tick();

`ifdef RF_ARB_LOCK_EN
        // Locked A bursts three writes on a 2-cycle cadence; B waits until the lock drops.
        applyStimulus(1, 1, 2'd0, 4'h1, 1, 0, 2'd0, 0);
        a_lock = 1'b1;
        resetPulse();
        done_cycle.delete();
        seen = 0;
        for (int c = 1; c <= 20 && done_cycle.size() < 3; c++) begin
            tick();
            if (b_gnt) seen = 1;
            if (a_done) begin
                done_cycle.push_back(c);
                a_addr  = a_addr + 2'd1;
                a_wdata = a_wdata + 4'h1;
                if (done_cycle.size() == 3) begin
                    a_lock = 1'b0;
                    a_req  = 1'b0;
                end
            end
        end
        checkOutput("t6_lock_done_count", done_cycle.size(), 3);
        if (done_cycle.size() == 3) begin
            checkOutput("t6_cadence_1", done_cycle[1] - done_cycle[0], 2);
            checkOutput("t6_cadence_2", done_cycle[2] - done_cycle[1], 2);
        end
        checkOutput("t6_b_blocked", seen, 0);
        seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            tick();
            seen = b_gnt;
        end
        checkOutput("t6_b_after_unlock", seen, 1);
        b_req = 1'b0;
        tick(); tick(); tick();
`endif

        // Randomized traffic, including occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 3) == 0, $urandom % 2, 2'($urandom), 4'($urandom),
                          ($urandom % 3) == 0, $urandom % 2, 2'($urandom), 4'($urandom));
`ifdef RF_ARB_LOCK_EN
            a_lock = ($urandom % 4) == 0;
            b_lock = ($urandom % 4) == 0;
`endif
            if (($urandom % 200) == 0) begin
                #2;
                clr = 1'b1;
                #1;
                checkOutput("rnd_rst_rf_write", rf_write, 0);
            end
            tick();
            clr = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
